// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: registers operands/op, waits the op-dependent
// settle time, then captures the result and returns it over a valid/ready response channel.
module alu_issue_ctrl #(
  parameter int WORD_SIZE    = 64,
  parameter int MULTI_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [WORD_SIZE-1:0] req_a,
  input  logic [WORD_SIZE-1:0] req_b,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_op,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] OP_MUL     = 4'd2;
  localparam logic [3:0] OP_DIV     = 4'd4;
  localparam logic [3:0] OP_MOD     = 4'd5;
  localparam logic [3:0] OP_EQ      = 4'd10;
  localparam logic [3:0] OP_NEQ     = 4'd11;
  localparam logic [3:0] MULTI_LOAD = 4'(MULTI_CYCLES - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic                 divz_q, divz_d;
  logic [WORD_SIZE-1:0] alu_a_q, alu_a_d;
  logic [WORD_SIZE-1:0] alu_b_q, alu_b_d;
  logic [3:0]           alu_op_q, alu_op_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 req_is_div;
  logic                 req_is_multi;
  logic                 req_divz;
  logic [WORD_SIZE-1:0] captured;

  assign req_ready    = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept       = req_valid && req_ready;
  assign req_is_div   = (req_op == OP_DIV) || (req_op == OP_MOD);
  assign req_is_multi = req_is_div || (req_op == OP_MUL);
  assign req_divz     = req_is_div && (req_b == '0);

  // The ALU's own NEQ is unreliable, so NEQ runs as EQ and bit 0 is inverted here.
  assign captured = (op_q == OP_NEQ) ? {{(WORD_SIZE-1){1'b0}}, ~alu_out[0]} : alu_out;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    divz_d   = divz_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (divz_q) begin
            result_d = '1;
            zero_d   = 1'b0;
            err_d    = 1'b1;
          end else begin
            result_d = captured;
            zero_d   = (captured == '0);
            err_d    = 1'b0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = req_valid ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept actions are shared by the IDLE and back-to-back RESP paths.
    if (accept) begin
      alu_a_d  = req_a;
      alu_b_d  = req_b;
      alu_op_d = (req_op == OP_NEQ) ? OP_EQ : req_op;
      op_d     = req_op;
      divz_d   = req_divz;
      cnt_d    = (req_is_multi && !req_divz) ? MULTI_LOAD : 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 4'd0;
      divz_q   <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 4'd0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      divz_q   <= divz_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed literal checks plus random traffic, all checked every
// cycle against a transaction-level model (latency countdown + pending response).
module tb_alu_issue_ctrl;

  localparam int W  = 64;
  localparam int MC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = 4'd0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [3:0]   alu_op;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_err, busy;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_ctrl #(.WORD_SIZE(W), .MULTI_CYCLES(MC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU as seen by the controller; its NEQ is deliberately wrong and
  // divide-by-zero returns junk, so the controller must not rely on either.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return a << b[5:0];
      4'd4:  return (b == '0) ? 64'hDEAD_BEEF : a / b;
      4'd5:  return (b == '0) ? 64'hDEAD_BEEF : a % b;
      4'd6:  return ~a;
      4'd7:  return a | b;
      4'd8:  return a & b;
      4'd9:  return a ^ b;
      4'd10: return W'(a == b);
      4'd11: return W'(a == b);
      4'd12: return W'(a < b);
      4'd13: return W'(a <= b);
      4'd14: return W'(a > b);
      default: return W'(a >= b);
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_op, alu_a, alu_b);

  function automatic logic [W-1:0] expect_fn(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    if ((op == 4'd4 || op == 4'd5) && b == '0) return '1;
    if (op == 4'd11) return W'(a != b);
    return alu_fn(op, a, b);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: cycles left until the in-flight op responds, plus the response.
  int           m_left;
  logic         m_rsp, m_err, m_pend_err;
  logic [W-1:0] m_res, m_pend_res, m_a, m_b;
  logic [3:0]   m_op;

  task automatic model_clear();
    m_left = 0; m_rsp = 0; m_err = 0; m_pend_err = 0;
    m_res = '0; m_pend_res = '0; m_a = '0; m_b = '0; m_op = 4'd0;
  endtask

  function automatic logic model_req_ready();
    return (m_left == 0 && !m_rsp) || (m_rsp && rsp_ready);
  endfunction

  task automatic model_step();
    logic acc, ret, divz;
    acc  = req_valid && model_req_ready();
    ret  = m_rsp && rsp_ready;
    divz = (req_op == 4'd4 || req_op == 4'd5) && req_b == '0;
    if (ret) m_rsp = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_rsp = 1; m_res = m_pend_res; m_err = m_pend_err;
      end
    end
    if (acc) begin
      m_left     = (!divz && (req_op == 4'd2 || req_op == 4'd4 || req_op == 4'd5)) ? MC : 1;
      m_pend_res = expect_fn(req_op, req_a, req_b);
      m_pend_err = divz;
      m_a = req_a; m_b = req_b;
      m_op = (req_op == 4'd11) ? 4'd10 : req_op;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (reset) model_clear(); else model_step();
      @(negedge clk); #3;
      if (reset) model_clear();
      chk("req_ready", W'(req_ready), W'(model_req_ready()));
      chk("rsp_valid", W'(rsp_valid), W'(m_rsp));
      chk("busy", W'(busy), W'(m_left > 0 || m_rsp));
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", W'(rsp_zero), W'(m_res == '0));
      chk("rsp_err", W'(rsp_err), W'(m_err));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", W'(alu_op), W'(m_op));
    end
  end

  task automatic wait_cycle();
    @(negedge clk); #1;
  endtask

  // Issue one op with rsp_ready high from IDLE; pin latency and result with literals.
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat, input logic [W-1:0] res,
                        input logic zero, input logic err, input logic [3:0] aop);
    int k;
    rsp_ready = 1; req_valid = 1; req_op = op; req_a = a; req_b = b;
    chk({name, "_req_ready"}, W'(req_ready), W'(1));
    wait_cycle();
    req_valid = 0;
    chk({name, "_alu_op"}, W'(alu_op), W'(aop));
    k = 0;
    do begin
      chk({name, "_alu_a_hold"}, alu_a, a);
      wait_cycle();
      k++;
    end while (!rsp_valid && k < 40);
    chk({name, "_latency"}, W'(k), W'(lat));
    chk({name, "_result"}, rsp_result, res);
    chk({name, "_zero"}, W'(rsp_zero), W'(zero));
    chk({name, "_err"}, W'(rsp_err), W'(err));
    wait_cycle();
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return W'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic hs;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hs;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_zero", W'(rsp_zero), W'(1));
    chk("reset_valid", W'(rsp_valid), W'(0));
    reset = 0;
    wait_cycle();

    run_op("add", 4'd0, 64'd5, 64'd7, 1, 64'd12, 0, 0, 4'd0);
    run_op("sub", 4'd1, 64'd9, 64'd9, 1, 64'd0, 1, 0, 4'd1);
    run_op("neq", 4'd11, 64'd3, 64'd4, 1, 64'd1, 0, 0, 4'd10);
    run_op("mul", 4'd2, 64'd6, 64'd7, MC, 64'd42, 0, 0, 4'd2);
    run_op("divz", 4'd4, 64'd100, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 4'd4);

    // Backpressure on XOR, then zero-bubble hand-off to AND.
    rsp_ready = 0; req_valid = 1; req_op = 4'd9; req_a = 64'hF0; req_b = 64'hFF;
    wait_cycle();
    req_valid = 0;
    wait_cycle();
    chk("xor_valid", W'(rsp_valid), W'(1));
    req_valid = 1; req_op = 4'd8; req_a = 64'hF0; req_b = 64'h3C;
    for (int i = 0; i < 3; i++) begin
      chk("xor_hold", rsp_result, 64'h0F);
      chk("xor_req_ready", W'(req_ready), W'(0));
      wait_cycle();
    end
    rsp_ready = 1;
    #1;
    chk("b2b_req_ready", W'(req_ready), W'(1));
    wait_cycle();
    req_valid = 0;
    chk("b2b_busy", W'(busy), W'(1));
    chk("b2b_alu_op", W'(alu_op), W'(8));
    wait_cycle();
    chk("and_valid", W'(rsp_valid), W'(1));
    chk("and_result", rsp_result, 64'h30);
    wait_cycle();

    // Reset two cycles into a MUL.
    req_valid = 1; req_op = 4'd2; req_a = 64'd6; req_b = 64'd7;
    wait_cycle();
    req_valid = 0;
    wait_cycle();
    wait_cycle();
    reset = 1;
    #1;
    chk("rst_valid", W'(rsp_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_zero", W'(rsp_zero), W'(1));
    wait_cycle();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      chk("rst_no_rsp", W'(rsp_valid), W'(0));
      wait_cycle();
    end
    run_op("add2", 4'd0, 64'd1, 64'd1, 1, 64'd2, 0, 0, 4'd0);

    // Random traffic; requester holds each request until it is taken.
    hs = 0;
    for (int n = 0; n < 600; n++) begin
      if (!req_valid || hs) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid = 1;
          req_op    = 4'($urandom_range(0, 15));
          req_a     = rnd_word();
          req_b     = rnd_word();
        end else begin
          req_valid = 0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs = req_valid && req_ready;
      @(negedge clk); #1;
    end
    req_valid = 0; rsp_ready = 1;
    repeat (10) wait_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
